// File: rtl/fir_sym_serial_pkg.sv
// fir_pkg: shared types and constants for the serial symmetric FIR.
//   fir_state_e  - sequencer states (IDLE / MAC / OUT)
//   def_coef()   - default 17-tap unique-coefficient table c0..c8
//                  (Q1.15 low-pass); any other length resets to all zero
//   acc_width()  - accumulator width that cannot overflow for H folded terms
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    localparam int DEF_TAPS = 17;

    // Unique half of the default table; only meaningful when taps == DEF_TAPS.
    function automatic logic signed [15:0] def_coef(input int i, input int taps);
        if (taps != DEF_TAPS) return 16'sd0;
        case (i)
            1:       return 16'sd241;
            2:       return 16'sd702;
            3:       return 16'sd1329;
            4:       return 16'sd2048;
            5:       return 16'sd2767;
            6:       return 16'sd3398;
            7:       return 16'sd3855;
            8:       return 16'sd4097;
            default: return 16'sd0;
        endcase
    endfunction

    // Pre-add adds one bit, the product adds COEF_W, and summing h terms adds clog2(h).
    function automatic int acc_width(input int data_w, input int coef_w, input int h);
        return data_w + coef_w + 1 + $clog2(h);
    endfunction

endpackage

// File: rtl/fir_sym_serial_if.sv
// fir_sym_serial_if: sample-in / result-out handshakes plus the coefficient
// write port of the serial symmetric FIR.
//   master - traffic source / result sink / coefficient writer
//   slave  - the filter
interface fir_sym_serial_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 17
);
    localparam int H  = (NUM_TAPS + 1) / 2;
    localparam int AW = $clog2(H);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sat;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_err;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, sat, coef_err
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, sat, coef_err
    );

endinterface

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: folded pre-add, single multiplier and accumulator.
//   clr          - zero the accumulator at the next edge
//   en           - acc += coef * (xa + xb), or coef * xa when use_b is low
//   acc_nxt      - value the accumulator takes at the next edge, so the
//                  caller can register a result in the same cycle as the
//                  final accumulation
module fir_mac_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     use_b,
    input  logic signed [DATA_W-1:0] xa,
    input  logic signed [DATA_W-1:0] xb,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc_nxt
);

    logic signed [DATA_W:0]        pre;
    logic signed [DATA_W+COEF_W:0] prod;
    logic signed [ACC_W-1:0]       acc_q, acc_d;

    always_comb begin
        pre = use_b ? ((DATA_W+1)'(xa) + (DATA_W+1)'(xb)) : (DATA_W+1)'(xa);
        prod = pre * coef;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    assign acc_nxt = acc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_sym_serial.sv
// fir_sym_serial: odd-length symmetric FIR with one time-shared multiplier.
// A sample is taken in IDLE, H folded MAC cycles follow, and the rounded
// result is held in OUT until it is taken.
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   bus (slave)   - in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//                   sat, coef_we/coef_addr/coef_data, coef_err
// Build option: define FIR_SAT_EN to clamp out_data to the DATA_W range and
// flag sat; otherwise the result wraps and sat stays 0.
module fir_sym_serial
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NUM_TAPS  = 17,
    parameter int FRAC_BITS = 15
) (
    input  logic clk,
    input  logic reset,
    fir_sym_serial_if.slave bus
);

    localparam int H     = (NUM_TAPS + 1) / 2;
    localparam int AW    = $clog2(H);
    localparam int MW    = $clog2(NUM_TAPS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, H);

    localparam logic [AW-1:0] LAST_IDX = AW'(H - 1);
    localparam logic [MW-1:0] TOP_TAP  = MW'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);

    fir_state_e                      state_q, state_d;
    logic [AW-1:0]                   idx_q, idx_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] x_q, x_d;
    logic [H-1:0][COEF_W-1:0]        coef_q, coef_d, coef_rst;
    logic [DATA_W-1:0]               out_data_q, out_data_d;
    logic                            sat_q, sat_d;
    logic                            coef_err_q, coef_err_d;

    logic                     mac_clr, mac_en, use_b;
    logic [MW-1:0]            mirror;
    logic signed [DATA_W-1:0] xa, xb;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [DATA_W-1:0]        rnd_data;
    logic                     rnd_sat;

    for (genvar g = 0; g < H; g++) begin : g_coef_rst
        assign coef_rst[g] = COEF_W'(def_coef(g, NUM_TAPS));
    end

    // Operand select: tap idx pairs with its mirror; the centre tap is unpaired.
    always_comb begin
        mirror = TOP_TAP - MW'(idx_q);
        xa     = x_q[MW'(idx_q)];
        xb     = x_q[mirror];
        c_sel  = coef_q[idx_q];
        use_b  = (idx_q != LAST_IDX);
    end

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (mac_clr),
        .en      (mac_en),
        .use_b   (use_b),
        .xa      (xa),
        .xb      (xb),
        .coef    (c_sel),
        .acc_nxt (acc_nxt)
    );

    // Round half up, then narrow to DATA_W.
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] rnd_full;

    always_comb begin
        rnd_full = (acc_nxt + HALF) >>> FRAC_BITS;
        rnd_data = rnd_full[DATA_W-1:0];
        rnd_sat  = 1'b0;
        if (rnd_full > SAT_MAX) begin
            rnd_data = SAT_MAX[DATA_W-1:0];
            rnd_sat  = 1'b1;
        end else if (rnd_full < SAT_MIN) begin
            rnd_data = SAT_MIN[DATA_W-1:0];
            rnd_sat  = 1'b1;
        end
    end
`else
    always_comb begin
        rnd_data = DATA_W'((acc_nxt + HALF) >>> FRAC_BITS);
        rnd_sat  = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        coef_d     = coef_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        coef_err_d = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;

        // Coefficients may only change while no sample is in flight.
        if (bus.coef_we) begin
            if (state_q == IDLE && int'(bus.coef_addr) < H) begin
                coef_d[bus.coef_addr] = bus.coef_data;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = {x_q[NUM_TAPS-2:0], bus.in_data};
                    mac_clr = 1'b1;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // acc_nxt already holds the final sum this cycle.
                    idx_d      = '0;
                    out_data_d = rnd_data;
                    sat_d      = rnd_sat;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            coef_q     <= coef_rst;
            out_data_q <= '0;
            sat_q      <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            coef_q     <= coef_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            coef_err_q <= coef_err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.sat       = sat_q;
    assign bus.coef_err  = coef_err_q;

endmodule
